// File: rtl/ins_aligner_pkg.sv
// Shared types and constants for the fetch-side instruction aligner.
// The RVC build of the aligner is selected with the macro INS_ALIGNER_RVC_EN.
package ins_aligner_pkg;

   typedef logic [15:0] halfword_t;

   localparam logic [1:0]  ILEN32       = 2'b11;
   localparam logic [31:0] PC_INC16     = 32'd2;
   localparam logic [31:0] PC_INC32     = 32'd4;
   localparam int          HW_DEPTH_MIN = 4;
   localparam int          HW_DEPTH_MAX = 6;

   function automatic bit hw_depth_legal(input int depth);
      return (depth == HW_DEPTH_MIN) || (depth == HW_DEPTH_MAX);
   endfunction

endpackage

// File: rtl/ins_aligner_hw_queue.sv
// Halfword FIFO for the aligner: pushes 0..2 entries at the tail, pops 0..2 from the head,
// and exposes the two head entries plus the fill count. Callers never overfill it.
module hw_queue
   import ins_aligner_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic [1:0]       i_push_n,
   input  halfword_t        i_push_d0,
   input  halfword_t        i_push_d1,
   input  logic [1:0]       i_pop_n,
   output halfword_t        o_q0,
   output halfword_t        o_q1,
   output logic [CNT_W-1:0] o_cnt
);

   halfword_t        r_q [DEPTH];
   halfword_t        w_nxt [DEPTH];
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nxt_cnt;
   int               w_base;

   always_comb begin
      w_nxt  = '{default: '0};
      w_base = int'(r_cnt) - int'(i_pop_n);
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (j == i + int'(i_pop_n)) w_nxt[i] = r_q[j];
         end
         if ((i_push_n != 2'd0) && (i == w_base))     w_nxt[i] = i_push_d0;
         if ((i_push_n == 2'd2) && (i == w_base + 1)) w_nxt[i] = i_push_d1;
      end
      w_nxt_cnt = CNT_W'(w_base + int'(i_push_n));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= '{default: '0};
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else begin
         r_q   <= w_nxt;
         r_cnt <= w_nxt_cnt;
      end
   end

   assign o_q0  = r_q[0];
   assign o_q1  = r_q[1];
   assign o_cnt = r_cnt;

endmodule

// File: rtl/ins_aligner.sv
// Instruction aligner feeding comp_decoder. With INS_ALIGNER_RVC_EN it aligns 16/32-bit
// instructions out of a halfword queue; without it the block is a one-word skid buffer.
module ins_aligner
   import ins_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH_HW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [31:0] fetch_data,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins,
   output logic [31:0] ins_pc
);

`ifdef INS_ALIGNER_RVC_EN
   localparam int DEPTH = hw_depth_legal(DEPTH_HW) ? DEPTH_HW : HW_DEPTH_MIN;
   localparam int CNT_W = $clog2(DEPTH + 1);

   halfword_t        w_q0, w_q1, w_d0;
   logic [CNT_W-1:0] w_cnt;
   logic [1:0]       w_push_n, w_pop_n;
   logic             w_is32, w_valid, w_push, w_pop;
   logic             r_skip_lo;
   logic [31:0]      r_pc;
   logic             w_unused;

   assign w_unused    = flush_pc[0];
   assign w_is32      = (w_q0[1:0] == ILEN32);
   assign w_valid     = !rst && (w_is32 ? (w_cnt >= CNT_W'(2)) : (w_cnt >= CNT_W'(1)));
   // Space is judged on the registered count only; a same-cycle pop does not help.
   assign fetch_ready = !rst && (w_cnt <= CNT_W'(DEPTH - 2));
   assign w_push      = fetch_valid && fetch_ready && !flush;
   assign w_pop       = w_valid && ins_ready && !flush;
   assign w_push_n    = w_push ? (r_skip_lo ? 2'd1 : 2'd2) : 2'd0;
   assign w_pop_n     = w_pop ? (w_is32 ? 2'd2 : 2'd1) : 2'd0;
   assign w_d0        = r_skip_lo ? fetch_data[31:16] : fetch_data[15:0];

   hw_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (flush),
      .i_push_n  (w_push_n),
      .i_push_d0 (w_d0),
      .i_push_d1 (fetch_data[31:16]),
      .i_pop_n   (w_pop_n),
      .o_q0      (w_q0),
      .o_q1      (w_q1),
      .o_cnt     (w_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_skip_lo <= 1'b0;
      end else if (flush) begin
         r_pc      <= {flush_pc[31:1], 1'b0};
         r_skip_lo <= flush_pc[1];
      end else begin
         if (w_pop)  r_pc      <= r_pc + (w_is32 ? PC_INC32 : PC_INC16);
         if (w_push) r_skip_lo <= 1'b0;
      end
   end

   assign ins_valid = w_valid;
   assign ins       = w_valid ? (w_is32 ? {w_q1, w_q0} : {16'h0000, w_q0}) : '0;
   assign ins_pc    = rst ? RESET_PC : r_pc;
`else
   logic        r_full;
   logic [31:0] r_word;
   logic [31:0] r_pc;
   logic        w_valid, w_push, w_pop;
   logic        w_unused;

   assign w_unused    = ^{flush_pc[1:0], hw_depth_legal(DEPTH_HW)};
   assign w_valid     = !rst && r_full;
   assign fetch_ready = !rst && (!r_full || ins_ready);
   assign w_push      = fetch_valid && fetch_ready && !flush;
   assign w_pop       = w_valid && ins_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= 1'b0;
         r_word <= '0;
         r_pc   <= RESET_PC;
      end else if (flush) begin
         r_full <= 1'b0;
         r_pc   <= {flush_pc[31:2], 2'b00};
      end else begin
         if (w_push)     r_full <= 1'b1;
         else if (w_pop) r_full <= 1'b0;
         if (w_push)     r_word <= fetch_data;
         if (w_pop)      r_pc   <= r_pc + PC_INC32;
      end
   end

   assign ins_valid = w_valid;
   assign ins       = w_valid ? r_word : '0;
   assign ins_pc    = rst ? RESET_PC : r_pc;
`endif

endmodule

// File: tb/tb_ins_aligner.sv
// Self-checking bench for ins_aligner: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model of the aligner.
module tb_ins_aligner;
   import ins_aligner_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst, fetch_valid, fetch_ready, flush, ins_valid, ins_ready;
   logic [31:0] fetch_data, flush_pc, ins, ins_pc;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mq[$];
   logic [31:0] mw[$];
   logic [31:0] m_pc;
   logic        m_skip;

   always #5 clk = ~clk;

   ins_aligner #(.RESET_PC(RST_PC), .DEPTH_HW(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_data  (fetch_data),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .ins         (ins),
      .ins_pc      (ins_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, compare against the model, then advance the model across the edge.
   task automatic step(input logic r, input logic fv, input logic [31:0] fd, input logic ir,
                       input logic fl, input logic [31:0] fpc);
      logic        e_valid, e_fr;
      logic [31:0] e_ins, e_pc;
      int          n_hw;
      @(negedge clk);
      rst = r; fetch_valid = fv; fetch_data = fd; ins_ready = ir; flush = fl; flush_pc = fpc;
      #1;
      e_valid = 1'b0; e_ins = '0; n_hw = 0;
      e_pc = r ? RST_PC : m_pc;
`ifdef INS_ALIGNER_RVC_EN
      if (!r && mq.size() >= 1 && mq[0][1:0] != 2'b11) begin
         e_valid = 1'b1; e_ins = {16'h0000, mq[0]}; n_hw = 1;
      end else if (!r && mq.size() >= 2 && mq[0][1:0] == 2'b11) begin
         e_valid = 1'b1; e_ins = {mq[1], mq[0]}; n_hw = 2;
      end
      e_fr = !r && (DEPTH - mq.size() >= 2);
`else
      if (!r && mw.size() == 1) begin
         e_valid = 1'b1; e_ins = mw[0];
      end
      e_fr = !r && (mw.size() == 0 || ir);
`endif
      chk("ins_valid", {31'b0, ins_valid}, {31'b0, e_valid});
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, e_fr});
      chk("ins_pc", ins_pc, e_pc);
      if (e_valid || r) chk("ins", ins, e_ins);

      if (r) begin
         mq.delete(); mw.delete(); m_pc = RST_PC; m_skip = 1'b0;
      end else if (fl) begin
         mq.delete(); mw.delete();
`ifdef INS_ALIGNER_RVC_EN
         m_pc = {fpc[31:1], 1'b0}; m_skip = fpc[1];
`else
         m_pc = {fpc[31:2], 2'b00};
`endif
      end else begin
`ifdef INS_ALIGNER_RVC_EN
         if (e_valid && ir) begin
            for (int k = 0; k < n_hw; k++) void'(mq.pop_front());
            m_pc = m_pc + 32'(2 * n_hw);
         end
         if (fv && e_fr) begin
            if (!m_skip) mq.push_back(fd[15:0]);
            mq.push_back(fd[31:16]);
            m_skip = 1'b0;
         end
`else
         if (e_valid && ir) begin
            void'(mw.pop_front());
            m_pc = m_pc + 32'd4;
         end
         if (fv && e_fr) mw.push_back(fd);
`endif
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic ir);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, ir, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] fd;
      rst = 1'b1; fetch_valid = 1'b0; fetch_data = '0; ins_ready = 1'b0;
      flush = 1'b0; flush_pc = '0;
      m_pc = RST_PC; m_skip = 1'b0;

      // two compressed in one word
      do_reset();
      step(1'b0, 1'b1, 32'h4501_0505, 1'b1, 1'b0, 32'h0);
      idle(4, 1'b1);

      // straddling 32-bit instruction, then an all-zero compressed halfword
      do_reset();
      step(1'b0, 1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0);
      idle(3, 1'b1);
      step(1'b0, 1'b1, 32'h0000_00A0, 1'b1, 1'b0, 32'h0);
      idle(4, 1'b1);

      // backpressure then release
      do_reset();
      step(1'b0, 1'b1, 32'h1111_0003, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h2222_0001, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0007_3333, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h4444_5555, 1'b0, 1'b0, 32'h0);
      idle(3, 1'b0);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 32'h6666_0000 + 32'(k), 1'b1, 1'b0, 32'h0);
      idle(8, 1'b1);

      // odd flush target drops the lower halfword
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
      step(1'b0, 1'b1, 32'h0505_1234, 1'b1, 1'b0, 32'h0);
      idle(3, 1'b1);

      // flush wins over same-cycle push and pop
      do_reset();
      step(1'b0, 1'b1, 32'h0909_0808, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'hABCD_0A0A, 1'b1, 1'b1, 32'h0000_2000);
      idle(3, 1'b1);

      // straddle half-buffered, then flush
      do_reset();
      step(1'b0, 1'b1, 32'h0013_0001, 1'b1, 1'b0, 32'h0);
      idle(1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040);
      idle(2, 1'b1);

      // reset mid-stream with three halfwords buffered
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0002);
      step(1'b0, 1'b1, 32'h0003_0011, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0022_0033, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      idle(3, 1'b1);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         fd = $urandom;
         if ($urandom_range(0, 1) == 1) fd[1:0] = 2'b11;
         if ($urandom_range(0, 1) == 1) fd[17:16] = 2'b11;
         step($urandom_range(0, 249) == 0, $urandom_range(0, 99) < 65, fd,
              $urandom_range(0, 99) < 60, $urandom_range(0, 39) == 0, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
